// File: rtl/miriscv_apb_pkg.sv
// Types, defaults and helpers for the miriscv core-to-APB bridge.
package miriscv_apb_pkg;

  import miriscv_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [XLEN-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Width needed to index n items, never less than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide constants shared by the miriscv data path and its peripherals.
package miriscv_pkg;

  localparam int XLEN = 32;

endpackage

// File: rtl/miriscv_apb_bridge_if.sv
// Core data-port and shared APB4 bus bundles used by the miriscv APB bridge.
interface miriscv_core_data_if;

  import miriscv_pkg::*;

  logic            req_i;
  logic            we_i;
  logic [3:0]      be_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            rvalid_o;
  logic [XLEN-1:0] rdata_o;
  logic            err_o;
  logic            busy_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rvalid_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rvalid_o, rdata_o, err_o, busy_o
  );

endinterface

interface miriscv_apb_if #(
  parameter int NUM_SLAVES = 4,
  parameter int PADDR_W    = 12
);

  import miriscv_pkg::*;

  logic [NUM_SLAVES-1:0]      psel_o;
  logic                       penable_o;
  logic                       pwrite_o;
  logic [PADDR_W-1:0]         paddr_o;
  logic [XLEN-1:0]            pwdata_o;
  logic [3:0]                 pstrb_o;
  logic [XLEN*NUM_SLAVES-1:0] prdata_i;
  logic [NUM_SLAVES-1:0]      pready_i;
  logic [NUM_SLAVES-1:0]      pslverr_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface

// File: rtl/miriscv_apb_bridge.sv
// Bridges the miriscv req/rvalid data port onto a shared APB4 bus with
// SETUP/ACCESS sequencing, wait states, slave errors, unmapped decode and timeout.
module miriscv_apb_bridge
  import miriscv_pkg::*;
  import miriscv_apb_pkg::*;
#(
  parameter int              NUM_SLAVES     = 4,
  parameter int              SEL_LSB        = 12,
  parameter int              PADDR_W        = 12,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  miriscv_core_data_if.slave   core,
  miriscv_apb_if.master        apb
);

  localparam int                 SEL_W    = sel_width(NUM_SLAVES);
  localparam int                 CNT_W    = sel_width(TIMEOUT_CYCLES);
  localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e            state;
  logic [CNT_W-1:0]      cnt;

  logic [SEL_W-1:0]      req_idx;
  logic [NUM_SLAVES-1:0] req_sel;
  logic                  req_mapped;

  logic                  sel_ready;
  logic                  sel_err;
  logic [XLEN-1:0]       sel_rdata;
  logic                  timeout_hit;
  logic                  unused_addr;

  assign req_idx     = core.addr_i[SEL_LSB +: SEL_W];
  assign unused_addr = ^core.addr_i;

  // Out-of-range indices produce an all-zero one-hot, which doubles as the unmapped flag.
  always_comb begin
    req_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_sel[k] = (req_idx == SEL_W'(k));
    end
  end

  assign req_mapped = |req_sel;

  // Only the slave currently holding psel is looked at; other slices never reach rdata.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (apb.psel_o[k]) begin
        sel_ready = apb.pready_i[k];
        sel_err   = apb.pslverr_i[k];
        sel_rdata = apb.prdata_i[XLEN*k +: XLEN];
      end
    end
  end

  assign timeout_hit  = TO_EN && (cnt == CNT_LAST);
  assign core.busy_o  = (state != IDLE);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state         <= IDLE;
      cnt           <= '0;
      core.rvalid_o <= 1'b0;
      core.err_o    <= 1'b0;
      core.rdata_o  <= '0;
      apb.psel_o    <= '0;
      apb.penable_o <= 1'b0;
      apb.pwrite_o  <= 1'b0;
      apb.paddr_o   <= '0;
      apb.pwdata_o  <= '0;
      apb.pstrb_o   <= '0;
    end else begin
      core.rvalid_o <= 1'b0;
      core.err_o    <= 1'b0;
      unique case (state)
        // Request capture and address decode
        IDLE: begin
          if (core.req_i) begin
            if (req_mapped) begin
              state        <= SETUP;
              apb.psel_o   <= req_sel;
              apb.pwrite_o <= core.we_i;
              apb.paddr_o  <= core.addr_i[PADDR_W-1:0];
              apb.pwdata_o <= core.wdata_i;
              apb.pstrb_o  <= core.we_i ? core.be_i : 4'b0000;
            end else begin
              core.rvalid_o <= 1'b1;
              core.err_o    <= 1'b1;
              core.rdata_o  <= core.we_i ? '0 : ERR_RDATA;
            end
          end
        end
        // SETUP phase: select already driven, enable follows next cycle
        SETUP: begin
          state         <= ACCESS;
          apb.penable_o <= 1'b1;
          cnt           <= '0;
        end
        // ACCESS phase: ready on the final cycle takes priority over the timeout
        ACCESS: begin
          if (sel_ready || timeout_hit) begin
            state         <= IDLE;
            cnt           <= '0;
            apb.psel_o    <= '0;
            apb.penable_o <= 1'b0;
            apb.pstrb_o   <= '0;
            core.rvalid_o <= 1'b1;
            if (sel_ready) begin
              core.err_o   <= sel_err;
              core.rdata_o <= apb.pwrite_o ? '0 : (sel_err ? ERR_RDATA : sel_rdata);
            end else begin
              core.err_o   <= 1'b1;
              core.rdata_o <= apb.pwrite_o ? '0 : ERR_RDATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
